tile_write_router: RTL and testbench

Write-side counterpart of the tile read path. Accepts a stream of DATA_WIDTH output elements from the PE/accumulator side over a valid/ready handshake and packs them little-endian into SRAM_DATA_WIDTH words. Writes each full word to the activation/output SRAM at sequential addresses from i_start_addr to i_addr_end. Sits between the compute array output and the SRAM write port, and drives the same write-enable/address/data interface the host otherwise drives.

---
 rtl/tile_write_router.sv | 145 ++++++++++++++
 tb/tb_tile_write_router.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_write_router.sv
// tile_write_router: packs a stream of DATA_WIDTH elements little-endian into
// SRAM_DATA_WIDTH words and writes them to sequential SRAM addresses from
// i_start_addr to i_addr_end inclusive. Termination is by address equality, so
// the range may wrap through the top of the address space.
// Build option: define TILE_WRITE_ROUTER_FLUSH_EN to add i_flush, which writes
// a partially filled word early, with the unfilled upper lanes set to zero.
// Handshake: an element transfers on a clock edge where i_data_valid and
// o_data_ready are both high. The source holds i_data until that edge.
// o_data_ready and o_sram_write_en are registered state qualified by i_en, so a
// stall (i_en low) stops transfers and defers a pending write strobe.
module tile_write_router #(
   parameter int DATA_WIDTH      = 8,
   parameter int SRAM_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH      = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_reg_clear,
   input  logic                       i_start,
   input  logic [ADDR_WIDTH-1:0]      i_start_addr,
   input  logic [ADDR_WIDTH-1:0]      i_addr_end,
   input  logic                       i_data_valid,
   input  logic [DATA_WIDTH-1:0]      i_data,
`ifdef TILE_WRITE_ROUTER_FLUSH_EN
   input  logic                       i_flush,
`endif
   output logic                       o_data_ready,
   output logic                       o_sram_write_en,
   output logic [ADDR_WIDTH-1:0]      o_sram_write_addr,
   output logic [SRAM_DATA_WIDTH-1:0] o_sram_data_out,
   output logic                       o_busy,
   output logic                       o_write_done
);

   localparam int LANES = SRAM_DATA_WIDTH / DATA_WIDTH;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

   state_t                     state;
   logic [SRAM_DATA_WIDTH-1:0] pack;
   logic [SRAM_DATA_WIDTH-1:0] pack_next;
   logic [SRAM_DATA_WIDTH-1:0] data_q;
   logic [LW-1:0]              lane;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [ADDR_WIDTH-1:0]      end_q;
   logic [ADDR_WIDTH-1:0]      waddr_q;
   logic                       accept;
   logic                       last_lane;
   logic                       flush_go;
   logic                       to_write;

   assign accept    = (state == PACK) && i_en && i_data_valid;
   assign last_lane = (lane == LW'(LANES - 1));

`ifdef TILE_WRITE_ROUTER_FLUSH_EN
   // A flush only counts once at least one lane holds data
   assign flush_go = (state == PACK) && i_en && i_flush && (lane != '0);
`else
   assign flush_go = 1'b0;
`endif

   assign to_write = (accept && last_lane) || flush_go;

   // Merge the element being accepted into its lane of the pack word
   always_comb begin
      pack_next = pack;
      for (int k = 0; k < LANES; k++) begin
         if (accept && (lane == LW'(k))) begin
            pack_next[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
         end
      end
   end

   // Control FSM plus pack, lane, address and write-port registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         pack    <= '0;
         lane    <= '0;
         addr_q  <= '0;
         end_q   <= '0;
         waddr_q <= '0;
         data_q  <= '0;
      end else if (i_reg_clear) begin
         state   <= IDLE;
         pack    <= '0;
         lane    <= '0;
         addr_q  <= '0;
         end_q   <= '0;
         waddr_q <= '0;
         data_q  <= '0;
      end else if (i_en) begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  addr_q <= i_start_addr;
                  end_q  <= i_addr_end;
                  lane   <= '0;
                  pack   <= '0;
                  state  <= PACK;
               end
            end
            PACK: begin
               pack <= pack_next;
               if (accept) begin
                  lane <= lane + 1'b1;
               end
               // Word and address are captured here so they are stable for
               // the whole WRITE cycle, however long a stall defers it.
               if (to_write) begin
                  data_q  <= pack_next;
                  waddr_q <= addr_q;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               pack <= '0;
               lane <= '0;
               if (addr_q == end_q) begin
                  state <= DONE;
               end else begin
                  addr_q <= addr_q + 1'b1;
                  state  <= PACK;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_data_ready      = (state == PACK) && i_en;
   assign o_sram_write_en   = (state == WRITE) && i_en;
   assign o_sram_write_addr = waddr_q;
   assign o_sram_data_out   = data_q;
   assign o_busy            = (state == PACK) || (state == WRITE);
   assign o_write_done      = (state == DONE);

endmodule

// File: tb/tb_tile_write_router.sv
// Testbench for tile_write_router: table-driven tiles, hand-written corner
// sequences and randomized tiles checked against a word-packing model.
module tb_tile_write_router;

   localparam int DW    = 8;
   localparam int SW    = 64;
   localparam int AW    = 8;
   localparam int LANES = SW / DW;

   logic          clk;
   logic          rst;
   logic          i_en;
   logic          i_reg_clear;
   logic          i_start;
   logic [AW-1:0] i_start_addr;
   logic [AW-1:0] i_addr_end;
   logic          i_data_valid;
   logic [DW-1:0] i_data;
`ifdef TILE_WRITE_ROUTER_FLUSH_EN
   logic          i_flush;
`endif
   logic          o_data_ready;
   logic          o_sram_write_en;
   logic [AW-1:0] o_sram_write_addr;
   logic [SW-1:0] o_sram_data_out;
   logic          o_busy;
   logic          o_write_done;

   tile_write_router #(
      .DATA_WIDTH(DW), .SRAM_DATA_WIDTH(SW), .ADDR_WIDTH(AW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_en(i_en),
      .i_reg_clear(i_reg_clear),
      .i_start(i_start),
      .i_start_addr(i_start_addr),
      .i_addr_end(i_addr_end),
      .i_data_valid(i_data_valid),
      .i_data(i_data),
`ifdef TILE_WRITE_ROUTER_FLUSH_EN
      .i_flush(i_flush),
`endif
      .o_data_ready(o_data_ready),
      .o_sram_write_en(o_sram_write_en),
      .o_sram_write_addr(o_sram_write_addr),
      .o_sram_data_out(o_sram_data_out),
      .o_busy(o_busy),
      .o_write_done(o_write_done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- bookkeeping ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          last_strobe_cyc = 0;
   int          done_cyc = 0;
   bit          done_seen = 0;
   logic [AW-1:0] obs_addr[$];
   logic [SW-1:0] obs_data[$];
   logic [DW-1:0] elem_q[$];

   always @(posedge clk) cyc++;

   // Monitor: record every strobe and the first cycle o_write_done is seen
   always @(negedge clk) begin
      if (o_sram_write_en) begin
         obs_addr.push_back(o_sram_write_addr);
         obs_data.push_back(o_sram_data_out);
         last_strobe_cyc = cyc;
         n_checks++;
         if (o_data_ready) begin
            n_errors++;
            $display("FAIL ready_in_write actual=1 required=0");
         end
      end
      if (o_write_done && !done_seen) begin
         done_seen = 1;
         done_cyc  = cyc;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (aligned at posedge+1) ----------------
   task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
      obs_addr.delete();
      obs_data.delete();
      done_seen    = 0;
      i_start_addr = s;
      i_addr_end   = e;
      i_start      = 1'b1;
      i_en         = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic do_clear();
      i_reg_clear = 1'b1;
      @(posedge clk); #1;
      i_reg_clear = 1'b0;
   endtask

   // vmode: 0 continuous, 1 every other cycle, 2 random; emode: 0 on, 1 random stalls
   task automatic send_range(input int lo, input int hi, input int vmode, input int emode);
      int idx = lo;
      int t = 0;
      while (idx < hi && t < 2000) begin
         case (vmode)
            0:       i_data_valid = 1'b1;
            1:       i_data_valid = (t % 2 == 0);
            default: i_data_valid = ($urandom_range(0, 3) != 0);
         endcase
         i_en   = (emode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
         i_data = elem_q[idx];
         @(negedge clk);
         if (!i_en) check("ready_while_stalled", o_data_ready, 0);
         if (i_data_valid && o_data_ready) idx++;
         @(posedge clk); #1;
         t++;
      end
      i_data_valid = 1'b0;
      i_en         = 1'b1;
      if (idx < hi) check("send_budget", idx, hi);
   endtask

   task automatic wait_done(input string tag);
      int b = 0;
      i_data_valid = 1'b0;
      i_en         = 1'b1;
      while (!o_write_done && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (!o_write_done) check({tag, "_done_timeout"}, 0, 1);
      @(posedge clk); #1;
   endtask

   // Reference model: word k is LANES consecutive elements, element j in bits
   // [8j+7:8j]; addresses run from s upward modulo 256 until e is reached.
   task automatic finish_tile(input logic [AW-1:0] s, input logic [AW-1:0] e, input string tag);
      logic [SW-1:0] exp_w[$];
      logic [AW-1:0] exp_a[$];
      logic [SW-1:0] w;
      int            n;
      wait_done(tag);
      n = ((int'(e) - int'(s)) & 255) + 1;
      for (int k = 0; k < n; k++) begin
         w = '0;
         for (int j = 0; j < LANES; j++) w = w | (SW'(elem_q[k*LANES + j]) << (8 * j));
         exp_w.push_back(w);
         exp_a.push_back(s + AW'(k));
      end
      check({tag, "_nwrites"}, obs_data.size(), n);
      for (int k = 0; k < n && k < obs_data.size(); k++) begin
         check({tag, "_addr"}, obs_addr[k], exp_a[k]);
         check({tag, "_data"}, obs_data[k], exp_w[k]);
      end
      check({tag, "_done_latency"}, done_cyc - last_strobe_cyc, 1);
      check({tag, "_busy_in_done"}, o_busy, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [AW-1:0] s;
      logic [AW-1:0] e;
      logic [DW-1:0] first;
      int            vmode;
      int            nw;
      logic [SW-1:0] w0;
      logic [SW-1:0] wl;
      logic [AW-1:0] al;
   } vec_t;

   vec_t tbl[4];

   initial begin
      logic [AW-1:0] rs;
      logic [AW-1:0] re;
      int            rn;

      tbl[0] = '{8'h00, 8'h01, 8'h01, 0, 2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 8'h01};
      tbl[1] = '{8'h00, 8'h01, 8'h01, 1, 2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 8'h01};
      tbl[2] = '{8'hFF, 8'h00, 8'h01, 0, 2, 64'h0807060504030201, 64'h100F0E0D0C0B0A09, 8'h00};
      tbl[3] = '{8'h10, 8'h10, 8'hA0, 0, 1, 64'hA7A6A5A4A3A2A1A0, 64'hA7A6A5A4A3A2A1A0, 8'h10};

      rst = 1'b1; i_en = 1'b0; i_reg_clear = 1'b0; i_start = 1'b0;
      i_start_addr = '0; i_addr_end = '0; i_data_valid = 1'b0; i_data = '0;
`ifdef TILE_WRITE_ROUTER_FLUSH_EN
      i_flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", o_data_ready, 0);
      check("rst_wen", o_sram_write_en, 0);
      check("rst_addr", o_sram_write_addr, 0);
      check("rst_data", o_sram_data_out, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_write_done, 0);
      rst = 1'b0;
      i_en = 1'b1;
      @(posedge clk); #1;

      // Table-driven tiles
      for (int v = 0; v < 4; v++) begin
         elem_q.delete();
         for (int i = 0; i < tbl[v].nw * LANES; i++) elem_q.push_back(tbl[v].first + DW'(i));
         do_start(tbl[v].s, tbl[v].e);
         check("busy_after_start", o_busy, 1);
         send_range(0, tbl[v].nw * LANES, tbl[v].vmode, 0);
         finish_tile(tbl[v].s, tbl[v].e, "vec");
         check("vec_count", obs_data.size(), tbl[v].nw);
         if (obs_data.size() > 0) begin
            check("vec_first_word", obs_data[0], tbl[v].w0);
            check("vec_last_word", obs_data[obs_data.size()-1], tbl[v].wl);
            check("vec_last_addr", obs_addr[obs_addr.size()-1], tbl[v].al);
         end
         do_clear();
         check("done_drop_after_clear", o_write_done, 0);
      end

      // Stall for 3 cycles after 4 accepted elements
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'(i + 1));
      do_start(8'h00, 8'h00);
      send_range(0, 4, 0, 0);
      i_en = 1'b0; i_data_valid = 1'b1; i_data = elem_q[4];
      repeat (3) begin
         @(negedge clk);
         check("stall_ready", o_data_ready, 0);
         @(posedge clk); #1;
      end
      check("stall_no_strobe", obs_data.size(), 0);
      send_range(4, 8, 0, 0);
      finish_tile(8'h00, 8'h00, "stall");
      if (obs_data.size() > 0) check("stall_word", obs_data[0], 64'h0807060504030201);
      do_clear();

      // Stall during the WRITE cycle: the strobe is deferred, not lost or doubled
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'(8'h11 + i));
      do_start(8'h20, 8'h20);
      send_range(0, 8, 0, 0);
      i_en = 1'b0;
      repeat (3) @(negedge clk);
      check("wstall_no_strobe", obs_data.size(), 0);
      @(posedge clk); #1;
      finish_tile(8'h20, 8'h20, "wstall");
      do_clear();

      // Clear after 5 elements: nothing written, back to idle
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'(8'h31 + i));
      do_start(8'h00, 8'h03);
      send_range(0, 5, 0, 0);
      do_clear();
      check("clear_busy", o_busy, 0);
      check("clear_ready", o_data_ready, 0);
      repeat (3) @(posedge clk);
      #1;
      check("clear_no_strobe", obs_data.size(), 0);
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'(8'hA0 + i));
      do_start(8'h10, 8'h10);
      send_range(0, 8, 0, 0);
      finish_tile(8'h10, 8'h10, "after_clear");
      if (obs_data.size() > 0) check("after_clear_word", obs_data[0], 64'hA7A6A5A4A3A2A1A0);

      // Start while DONE is ignored
      do_start(8'h60, 8'h61);
      repeat (3) @(posedge clk);
      #1;
      check("start_in_done_done", o_write_done, 1);
      check("start_in_done_busy", o_busy, 0);
      check("start_in_done_nowrite", obs_data.size(), 0);

      // Asynchronous reset takes effect without a clock edge
      #2; rst = 1'b1; #1;
      check("arst_done", o_write_done, 0);
      check("arst_addr", o_sram_write_addr, 0);
      check("arst_data", o_sram_data_out, 0);
      @(posedge clk); #1; rst = 1'b0;

      // Reset mid-PACK discards the partial word
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'($urandom_range(0, 255)));
      do_start(8'h50, 8'h50);
      send_range(0, 3, 0, 0);
      #2; rst = 1'b1; #1;
      check("arst_pack_busy", o_busy, 0);
      check("arst_pack_ready", o_data_ready, 0);
      @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 8; i++) elem_q[i] = DW'($urandom_range(0, 255));
      do_start(8'h50, 8'h50);
      send_range(0, 8, 0, 0);
      finish_tile(8'h50, 8'h50, "after_rst");
      do_clear();

`ifdef TILE_WRITE_ROUTER_FLUSH_EN
      // Flush a 3-element partial word
      elem_q.delete();
      for (int i = 0; i < 3; i++) elem_q.push_back(DW'(i + 1));
      do_start(8'h30, 8'h30);
      send_range(0, 3, 0, 0);
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      wait_done("flush");
      check("flush_nwrites", obs_data.size(), 1);
      if (obs_data.size() > 0) begin
         check("flush_addr", obs_addr[0], 8'h30);
         check("flush_word", obs_data[0], 64'h0000000000030201);
      end
      do_clear();
      // Flush with an empty word does nothing
      elem_q.delete();
      for (int i = 0; i < 8; i++) elem_q.push_back(DW'(8'hC0 + i));
      do_start(8'h40, 8'h40);
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("flush_empty_nowrite", obs_data.size(), 0);
      send_range(0, 8, 0, 0);
      finish_tile(8'h40, 8'h40, "flush_empty");
      do_clear();
`endif

      // Randomized tiles with gaps and stalls
      for (int r = 0; r < 6; r++) begin
         rs = AW'($urandom_range(0, 255));
         re = rs + AW'($urandom_range(0, 2));
         rn = ((int'(re) - int'(rs)) & 255) + 1;
         elem_q.delete();
         for (int i = 0; i < rn * LANES; i++) elem_q.push_back(DW'($urandom_range(0, 255)));
         do_start(rs, re);
         send_range(0, rn * LANES, 2, 1);
         finish_tile(rs, re, "rand");
         do_clear();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
